// File: rtl/dump_stage_mb_pkg.sv
// Shared types and constants for the Keccak output dump stage.
package dump_stage_mb_pkg;

    typedef enum logic [1:0] {
        OP_SHAKE128 = 2'd0,
        OP_SHAKE256 = 2'd1,
        OP_SHA3_256 = 2'd2,
        OP_SHA3_512 = 2'd3
    } op_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_BLK = 2'd2,
        ST_DRAIN    = 2'd3
    } dump_state_t;

    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;
    localparam int RATE_SHA3_256 = 1088;
    localparam int RATE_SHA3_512 = 576;

    localparam int SHA3_256_OUT = 256;
    localparam int SHA3_512_OUT = 512;

    // Rate in bits of one squeeze block for the given mode.
    function automatic int unsigned rate_of(input op_mode_t mode);
        case (mode)
            OP_SHAKE128: return RATE_SHAKE128;
            OP_SHAKE256: return RATE_SHAKE256;
            OP_SHA3_256: return RATE_SHA3_256;
            default:     return RATE_SHA3_512;
        endcase
    endfunction

endpackage

// File: rtl/dump_stage_mb_if.sv
// Output word stream of the dump stage: W-bit data, byte keep, last, valid/ready.
interface dump_stage_mb_if #(
    parameter int W = 64
);
    logic [W-1:0]   data_out;
    logic [W/8-1:0] data_keep;
    logic           last_out;
    logic           valid_out;
    logic           ready_in;

    modport master (
        output data_out, data_keep, last_out, valid_out,
        input  ready_in
    );

    modport slave (
        input  data_out, data_keep, last_out, valid_out,
        output ready_in
    );
endinterface

// File: rtl/dump_stage_mb_slot_ring.sv
// Ring of squeeze-block slots with per-slot word count and last tag.
module dump_slot_ring #(
    parameter int NUM_BUF  = 2,
    parameter int RATE_MAX = 1344,
    parameter int IDX_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [RATE_MAX-1:0] wr_data,
    input  logic [IDX_W-1:0]    wr_words,
    input  logic                wr_last,
    input  logic                rd_retire,
    output logic                available,
    output logic                occupied,
    output logic                occupied_next,
    output logic [RATE_MAX-1:0] rd_data,
    output logic [IDX_W-1:0]    rd_words,
    output logic                rd_last
);
    localparam int PTR_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
    localparam int CNT_W = $clog2(NUM_BUF + 1);

    logic [RATE_MAX-1:0] slot_data  [NUM_BUF];
    logic [IDX_W-1:0]    slot_words [NUM_BUF];
    logic [NUM_BUF-1:0]  slot_last;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_BUF - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy after this cycle; a write and a retire together cancel out.
    always_comb begin
        count_next = count;
        if (wr_en && !rd_retire) begin
            count_next = count + CNT_W'(1);
        end else if (!wr_en && rd_retire) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Pointers, occupancy and last tags; reset empties the ring.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            slot_last <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr            <= ptr_inc(wr_ptr);
                slot_last[wr_ptr] <= wr_last;
            end
            if (rd_retire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_next;
        end
    end

    // Block payload storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            slot_data[wr_ptr]  <= wr_data;
            slot_words[wr_ptr] <= wr_words;
        end
    end

    assign available     = (count != CNT_W'(NUM_BUF));
    assign occupied      = (count != '0);
    assign occupied_next = (count_next != '0);
    assign rd_data       = slot_data[rd_ptr];
    assign rd_words      = slot_words[rd_ptr];
    assign rd_last       = slot_last[rd_ptr];

endmodule

// File: rtl/dump_stage_mb.sv
// Keccak output stage: buffers squeeze blocks and serialises them as trimmed W-bit words.
module dump_stage_mb
    import dump_stage_mb_pkg::*;
#(
    parameter int W        = 64,
    parameter int NUM_BUF  = 2,
    parameter int RATE_MAX = 1344,
    parameter int SIZE_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RATE_MAX-1:0] rate_output,
    input  logic [SIZE_W-1:0]   output_size,
    input  logic [1:0]          operation_mode,
    input  logic                output_buffer_we,
    input  logic                last_output_block,
    output logic                output_buffer_available_wr,
    output logic                last_output_block_clr,
    dump_stage_mb_if.master     stream
);
    localparam int WORDS_MAX = RATE_MAX / W;
    localparam int IDX_W     = $clog2(WORDS_MAX + 1);
    localparam int KEEP_W    = W / 8;

    op_mode_t            wr_mode;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_words;
    logic [SIZE_W-1:0]   req_len;
    logic                available;
    logic                occupied;
    logic                occupied_next;
    logic [RATE_MAX-1:0] rd_data;
    logic [IDX_W-1:0]    rd_words;
    logic                rd_last;
    logic [SIZE_W-1:0]   remaining;
    logic [SIZE_W-1:0]   remaining_next;
    logic [IDX_W-1:0]    word_idx;
    logic                request_active;
    logic                active_next;
    dump_state_t         state;
    dump_state_t         state_next;
    logic                valid;
    logic                xfer;
    logic                final_word;
    logic                retire;
    logic                retire_last;
    logic [W-1:0]        raw_word;
    logic [W-1:0]        bit_mask;
    logic [KEEP_W-1:0]   keep;

    assign wr_mode  = op_mode_t'(operation_mode);
    assign wr_en    = output_buffer_we && available;
    assign wr_words = IDX_W'(rate_of(wr_mode) / W);

    dump_slot_ring #(
        .NUM_BUF  (NUM_BUF),
        .RATE_MAX (RATE_MAX),
        .IDX_W    (IDX_W)
    ) u_ring (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (rate_output),
        .wr_words      (wr_words),
        .wr_last       (last_output_block),
        .rd_retire     (retire),
        .available     (available),
        .occupied      (occupied),
        .occupied_next (occupied_next),
        .rd_data       (rd_data),
        .rd_words      (rd_words),
        .rd_last       (rd_last)
    );

    // Requested length: SHAKE follows output_size, SHA3 uses its fixed digest size.
    always_comb begin
        req_len = output_size;
        case (wr_mode)
            OP_SHA3_256: req_len = SIZE_W'(SHA3_256_OUT);
            OP_SHA3_512: req_len = SIZE_W'(SHA3_512_OUT);
            default:     req_len = output_size;
        endcase
    end

    assign valid       = occupied && (remaining != '0);
    assign xfer        = valid && stream.ready_in;
    assign final_word  = (remaining <= SIZE_W'(W));
    assign retire      = (xfer && ((word_idx == rd_words - IDX_W'(1)) || final_word))
                         || (state == ST_DRAIN);
    assign retire_last = retire && rd_last;
    assign raw_word    = rd_data[word_idx * W +: W];

    // Final-word trim: keep covers partial bytes, data bits past the length read as zero.
    always_comb begin
        bit_mask = '1;
        keep     = '1;
        if (final_word) begin
            for (int i = 0; i < W; i++) begin
                bit_mask[i] = (SIZE_W'(i) < remaining);
            end
            for (int b = 0; b < KEEP_W; b++) begin
                keep[b] = (SIZE_W'(b * 8) < remaining);
            end
        end
    end

    // Remaining length and request tracking; a new request may start as the old one retires.
    always_comb begin
        remaining_next = remaining;
        active_next    = request_active;
        if (xfer) begin
            remaining_next = final_word ? '0 : remaining - SIZE_W'(W);
        end
        if (retire_last) begin
            active_next = 1'b0;
        end
        if (wr_en && (!request_active || retire_last)) begin
            remaining_next = req_len;
            active_next    = 1'b1;
        end
    end

    // Next control state; DRAIN means a slot is present but nothing is left to send.
    always_comb begin
        if (occupied_next && (remaining_next == '0)) begin
            state_next = ST_DRAIN;
        end else if (active_next && occupied_next) begin
            state_next = ST_STREAM;
        end else if (active_next) begin
            state_next = ST_WAIT_BLK;
        end else begin
            state_next = ST_IDLE;
        end
    end

    // Control FSM with its counters and the registered retire-of-last pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= ST_IDLE;
            remaining             <= '0;
            request_active        <= 1'b0;
            word_idx              <= '0;
            last_output_block_clr <= 1'b0;
        end else begin
            state          <= state_next;
            remaining      <= remaining_next;
            request_active <= active_next;
            if (retire) begin
                word_idx <= '0;
            end else if (xfer) begin
                word_idx <= word_idx + IDX_W'(1);
            end
            last_output_block_clr <= retire_last;
        end
    end

    assign output_buffer_available_wr = available;
    assign stream.valid_out = valid;
    assign stream.data_out  = valid ? (raw_word & bit_mask) : '0;
    assign stream.data_keep = valid ? keep : '0;
    assign stream.last_out  = valid && final_word;

endmodule
